// File: rtl/button_bank.sv
// Memory-mapped bank of active-low push buttons: 2-FF synchroniser, per-channel
// debounce, sticky press/release flags with W1C clear, and a level interrupt.
module button_bank #(
  parameter int NUM_BTN         = 4,
  parameter int DEBOUNCE_CYCLES = 250000,
  localparam int CNT_W          = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [NUM_BTN-1:0] btn_in,
  input  logic               ren,
  input  logic               wen,
  input  logic [31:0]        address,
  input  logic [31:0]        data_in,
  output logic [31:0]        data_out,
  output logic               irq
);

  logic [NUM_BTN-1:0] sync1;
  logic [NUM_BTN-1:0] sync2;
  logic [NUM_BTN-1:0] stable;
  logic [CNT_W-1:0]   cnt [NUM_BTN];
  logic [NUM_BTN-1:0] accept;
  logic [NUM_BTN-1:0] press_flag;
  logic [NUM_BTN-1:0] release_flag;
  logic [1:0]         irq_en;
  logic [NUM_BTN-1:0] press_clr;
  logic [NUM_BTN-1:0] release_clr;
  logic [1:0]         sel;
  logic [31:0]        rdata;
  logic               unused;

  assign sel    = address[3:2];
  assign unused = &{1'b0, address[31:4], address[1:0], data_in};

  // A channel flips its stable level on the cycle its mismatch run completes.
  always_comb begin
    accept = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      accept[i] = (sync2[i] != stable[i]) && (cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1));
    end
  end

  assign press_clr   = (wen && sel == 2'd1) ? data_in[NUM_BTN-1:0] : '0;
  assign release_clr = (wen && sel == 2'd2) ? data_in[NUM_BTN-1:0] : '0;

  always_comb begin
    rdata = '0;
    case (sel)
      2'd0:    rdata[NUM_BTN-1:0] = stable;
      2'd1:    rdata[NUM_BTN-1:0] = press_flag;
      2'd2:    rdata[NUM_BTN-1:0] = release_flag;
      default: rdata[1:0]         = irq_en;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1  <= '1;
      sync2  <= '1;
      stable <= '1;
      for (int i = 0; i < NUM_BTN; i++) cnt[i] <= '0;
    end else begin
      sync1 <= btn_in;
      sync2 <= sync1;
      for (int i = 0; i < NUM_BTN; i++) begin
        if (sync2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (accept[i]) begin
          cnt[i]    <= '0;
          stable[i] <= sync2[i];
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Set terms are OR-ed after the clear so a coincident event is never lost.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      press_flag   <= '0;
      release_flag <= '0;
      irq_en       <= '0;
      data_out     <= '0;
      irq          <= 1'b0;
    end else begin
      press_flag   <= (press_flag & ~press_clr) | (accept & stable);
      release_flag <= (release_flag & ~release_clr) | (accept & ~stable);
      if (wen && sel == 2'd3) irq_en <= data_in[1:0];
      if (ren) data_out <= rdata;
      irq <= (irq_en[0] & (|press_flag)) | (irq_en[1] & (|release_flag));
    end
  end

endmodule

// File: tb/tb_button_bank.sv
// Bench for button_bank: directed scenarios plus random traffic, checked every
// cycle against a sliding-window reference model of debounce and the register file.
module tb_button_bank;

  localparam int N = 4;
  localparam int D = 8;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic [N-1:0]  btn_in = '1;
  logic          ren = 1'b0;
  logic          wen = 1'b0;
  logic [31:0]   address = '0;
  logic [31:0]   data_in = '0;
  logic [31:0]   data_out;
  logic          irq;

  int n_cmp = 0;
  int n_err = 0;

  button_bank #(.NUM_BTN(N), .DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .resetn(resetn), .btn_in(btn_in), .ren(ren), .wen(wen),
    .address(address), .data_in(data_in), .data_out(data_out), .irq(irq)
  );

  always #5 clk = ~clk;

  // Reference model. hist[m] is the pin value seen just before the edge m cycles
  // ago; a channel accepts a new level when every pin sample that has reached the
  // far end of the synchroniser over the last D edges disagrees with its level.
  logic [N-1:0] hist [D+2];
  logic [N-1:0] m_stable, m_press, m_rel, m_acc, m_pclr, m_rclr;
  logic [1:0]   m_en;
  logic [31:0]  m_dout, m_rd;
  logic         m_irq;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int j = 0; j < D + 2; j++) hist[j] = '1;
      m_stable = '1; m_press = '0; m_rel = '0; m_en = '0; m_dout = '0; m_irq = 1'b0;
    end else begin
      for (int j = D + 1; j > 0; j--) hist[j] = hist[j-1];
      hist[0] = btn_in;
      m_acc = '1;
      for (int j = 2; j <= D + 1; j++) m_acc = m_acc & (hist[j] ^ m_stable);
      case (address[3:2])
        2'd0:    m_rd = 32'(m_stable);
        2'd1:    m_rd = 32'(m_press);
        2'd2:    m_rd = 32'(m_rel);
        default: m_rd = 32'(m_en);
      endcase
      m_irq  = (m_en[0] && m_press != 0) || (m_en[1] && m_rel != 0);
      m_pclr = (wen && address[3:2] == 2'd1) ? data_in[N-1:0] : '0;
      m_rclr = (wen && address[3:2] == 2'd2) ? data_in[N-1:0] : '0;
      m_press = (m_press & ~m_pclr) | (m_acc & m_stable);
      m_rel   = (m_rel & ~m_rclr) | (m_acc & ~m_stable);
      if (wen && address[3:2] == 2'd3) m_en = data_in[1:0];
      if (ren) m_dout = m_rd;
      m_stable = m_stable ^ m_acc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      chk("model_dout", data_out, m_dout);
      chk("model_irq", 32'(irq), 32'(m_irq));
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    wen = 1'b1; address = a; data_in = d;
    step(1);
    wen = 1'b0; data_in = '0;
  endtask

  task automatic bus_read(input logic [31:0] a, input string tag, input logic [31:0] exp);
    ren = 1'b1; address = a;
    step(1);
    ren = 1'b0;
    chk(tag, data_out, exp);
  endtask

  int n;

  initial begin
    step(3);
    resetn = 1'b1;
    chk("reset_dout", data_out, 32'h0);
    chk("reset_irq", 32'(irq), 32'h0);
    step(2);
    bus_read(32'h0, "reset_level", 32'h0000000F);
    bus_read(32'h4, "reset_press", 32'h0);
    bus_read(32'h8, "reset_release", 32'h0);

    // Clean press on ch2 while LEVEL is read every cycle.
    ren = 1'b1; address = 32'h0;
    btn_in[2] = 1'b0;
    n = 0;
    do begin step(1); n++; end while (data_out[2] !== 1'b0 && n < 40);
    chk("press2_latency", 32'(n), 32'd11);
    bus_read(32'h4, "press2_flag", 32'h4);
    bus_write(32'h4, 32'h4);
    btn_in[2] = 1'b1;
    step(12);
    bus_write(32'h8, 32'h4);

    // Bouncy press on ch0: only the final low run counts.
    ren = 1'b1; address = 32'h0;
    btn_in[0] = 1'b0; step(3);
    btn_in[0] = 1'b1; step(1);
    btn_in[0] = 1'b0;
    n = 0;
    do begin step(1); n++; end while (data_out[0] !== 1'b0 && n < 40);
    chk("bounce0_latency", 32'(n), 32'd11);
    step(10);
    bus_read(32'h4, "bounce0_press", 32'h1);
    btn_in[0] = 1'b1;
    step(12);
    bus_write(32'h4, 32'hF);
    bus_write(32'h8, 32'hF);
    bus_read(32'h8, "flags_cleared", 32'h0);

    // Press interrupt on ch1.
    bus_write(32'hC, 32'h1);
    btn_in[1] = 1'b0;
    n = 0;
    do begin step(1); n++; end while (irq !== 1'b1 && n < 40);
    chk("irq1_latency", 32'(n), 32'd11);
    bus_write(32'h4, 32'h2);
    chk("irq1_hold", 32'(irq), 32'h1);
    step(1);
    chk("irq1_fall", 32'(irq), 32'h0);
    btn_in[1] = 1'b1;
    step(12);
    bus_write(32'h8, 32'h2);
    // W1C lands on the very edge the new press is accepted.
    btn_in[1] = 1'b0;
    step(9);
    bus_write(32'h4, 32'h2);
    bus_read(32'h4, "set_beats_clear", 32'h2);
    bus_write(32'h4, 32'h2);
    btn_in[1] = 1'b1;
    step(12);
    bus_write(32'h8, 32'h2);

    // Release interrupt on ch3.
    bus_write(32'hC, 32'h2);
    btn_in[3] = 1'b0; step(12);
    btn_in[3] = 1'b1; step(12);
    bus_read(32'h8, "release3_flag", 32'h8);
    chk("release3_irq", 32'(irq), 32'h1);
    bus_write(32'h8, 32'h0);
    bus_read(32'h8, "w1c_zero", 32'h8);
    bus_write(32'h8, 32'h8);
    bus_read(32'h8, "w1c_one", 32'h0);
    step(1);
    chk("release3_irq_fall", 32'(irq), 32'h0);

    // Async reset in the middle of a debounce run (press flag ch3 still set).
    bus_write(32'hC, 32'h3);
    bus_read(32'h0, "pre_reset_level", 32'hF);
    chk("pre_reset_irq", 32'(irq), 32'h1);
    btn_in[1] = 1'b0;
    step(7);
    #2 resetn = 1'b0;
    #1;
    chk("async_dout", data_out, 32'h0);
    chk("async_irq", 32'(irq), 32'h0);
    btn_in = '1;
    step(2);
    resetn = 1'b1;
    bus_read(32'hC, "reset_irq_en", 32'h0);
    bus_read(32'h4, "reset_press2", 32'h0);
    // A pulse one cycle short of DEBOUNCE_CYCLES must be rejected.
    btn_in[0] = 1'b0; step(D - 1);
    btn_in[0] = 1'b1; step(20);
    bus_read(32'h4, "short_pulse_press", 32'h0);
    bus_read(32'h0, "short_pulse_level", 32'hF);

    // Random buttons and bus traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) if ($urandom_range(11) == 0) btn_in[i] = ~btn_in[i];
      ren     = 1'($urandom_range(1));
      wen     = ($urandom_range(5) == 0);
      address = $urandom;
      data_in = $urandom;
      step(1);
    end
    ren = 1'b0; wen = 1'b0;
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
